// File: rtl/fdiv_share_arb.sv
// fdiv_share_arb: shares one fixed-latency pipelined FP divider among NREQ
// requesters. Grants one requester per cycle, registers its operands into the
// divider, tracks the owner in a tag pipe matching the divider latency and
// routes each result back. Provides a flush/drain handshake and a sticky
// tag-mismatch error.
// Build option: define FDIV_ARB_FIXPRIO_EN for fixed priority (lowest index
// wins); otherwise round-robin arbitration is used.
module fdiv_share_arb #(
  parameter int EXP  = 5,
  parameter int FRA  = 10,
  parameter int NREQ = 4,
  parameter int LAT  = 4
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*(EXP+FRA+1)-1:0]   req_a,
  input  logic [NREQ*(EXP+FRA+1)-1:0]   req_b,
  output logic [NREQ-1:0]               req_ready,
  output logic [EXP+FRA:0]              div_a_tdata,
  output logic [EXP+FRA:0]              div_b_tdata,
  output logic                          div_a_tvalid,
  output logic                          div_b_tvalid,
  input  logic [EXP+FRA:0]              div_result_tdata,
  input  logic                          div_result_tvalid,
  input  logic [2:0]                    div_flag,
  output logic [NREQ-1:0]               rsp_valid,
  output logic [EXP+FRA:0]              rsp_data,
  output logic [2:0]                    rsp_flag,
  input  logic                          flush,
  output logic                          flush_done,
  output logic                          busy,
  output logic                          err
);

  localparam int W   = EXP + FRA + 1;
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW  = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;

  logic [W-1:0]      req_a_s [NREQ];
  logic [W-1:0]      req_b_s [NREQ];

  logic              gnt_any_s;
  logic [IDW-1:0]    gnt_id_s;
  logic              arb_en_s;
  logic              gnt_fire_s;

  logic              div_tvalid_r;
  logic [W-1:0]      div_a_r;
  logic [W-1:0]      div_b_r;
  logic [IDW-1:0]    div_id_r;

  logic [LAT-1:0]    tag_vld_r;
  logic [IDW-1:0]    tag_id_r [LAT];

  logic [GW-1:0]     guard_cnt_r;
  logic              guard_done_s;

  logic [NREQ-1:0]   rsp_valid_r;
  logic [W-1:0]      rsp_data_r;
  logic [2:0]        rsp_flag_r;
  logic              err_r;
  logic              flush_done_r;
  logic              busy_s;

`ifndef FDIV_ARB_FIXPRIO_EN
  logic [IDW-1:0]    p_r;
  logic [IDW:0]      rr_sum_s;
  logic [IDW-1:0]    rr_idx_s;
`endif

  // One-hot decode of a requester id.
  function automatic logic [NREQ-1:0] id2oh(input logic [IDW-1:0] id);
    logic [NREQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign req_a_s[gi] = req_a[gi*W +: W];
    assign req_b_s[gi] = req_b[gi*W +: W];
  end

  assign busy_s       = (|tag_vld_r) | div_tvalid_r;
  assign guard_done_s = (guard_cnt_r == '0);
  assign arb_en_s     = aresetn & (state_r == ST_RUN) & ~flush;
  assign gnt_fire_s   = gnt_any_s & arb_en_s;

  // Select the winning requester (fixed priority or round-robin from p).
  always_comb begin
    gnt_any_s = 1'b0;
    gnt_id_s  = '0;
`ifdef FDIV_ARB_FIXPRIO_EN
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_any_s && req_valid[k]) begin
        gnt_any_s = 1'b1;
        gnt_id_s  = IDW'(k);
      end else begin
        gnt_any_s = gnt_any_s;
      end
    end
`else
    rr_sum_s = '0;
    rr_idx_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      rr_sum_s = {1'b0, p_r} + (IDW+1)'(k);
      if (rr_sum_s >= (IDW+1)'(NREQ)) begin
        rr_idx_s = IDW'(rr_sum_s - (IDW+1)'(NREQ));
      end else begin
        rr_idx_s = rr_sum_s[IDW-1:0];
      end
      if (!gnt_any_s && req_valid[rr_idx_s]) begin
        gnt_any_s = 1'b1;
        gnt_id_s  = rr_idx_s;
      end else begin
        gnt_any_s = gnt_any_s;
      end
    end
`endif
  end

  // Drive the one-hot ready only when arbitration is enabled.
  always_comb begin
    req_ready = '0;
    if (gnt_fire_s) begin
      req_ready = id2oh(gnt_id_s);
    end else begin
      req_ready = '0;
    end
  end

`ifndef FDIV_ARB_FIXPRIO_EN
  // Round-robin pointer: moves past the last granted requester.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      p_r <= '0;
    end else if (gnt_fire_s) begin
      p_r <= (gnt_id_s == IDW'(NREQ-1)) ? '0 : gnt_id_s + IDW'(1);
    end
  end
`endif

  // Register the granted operands and owner id into the divider.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      div_tvalid_r <= 1'b0;
      div_a_r      <= '0;
      div_b_r      <= '0;
      div_id_r     <= '0;
    end else begin
      div_tvalid_r <= gnt_fire_s;
      if (gnt_fire_s) begin
        div_a_r  <= req_a_s[gnt_id_s];
        div_b_r  <= req_b_s[gnt_id_s];
        div_id_r <= gnt_id_s;
      end
    end
  end

  // Tag pipe shadowing the divider pipeline.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      tag_vld_r <= '0;
      for (int s = 0; s < LAT; s++) begin
        tag_id_r[s] <= '0;
      end
    end else begin
      tag_vld_r[0] <= div_tvalid_r;
      tag_id_r[0]  <= div_id_r;
      for (int s = 1; s < LAT; s++) begin
        tag_vld_r[s] <= tag_vld_r[s-1];
        tag_id_r[s]  <= tag_id_r[s-1];
      end
    end
  end

  // Post-reset guard: absorbs results of operations discarded by reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      guard_cnt_r <= GW'(LAT);
    end else if (guard_cnt_r != '0) begin
      guard_cnt_r <= guard_cnt_r - GW'(1);
    end
  end

  // Match result against tag, route response or raise sticky error.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rsp_valid_r <= '0;
      rsp_data_r  <= '0;
      rsp_flag_r  <= 3'b000;
      err_r       <= 1'b0;
    end else begin
      rsp_valid_r <= '0;
      if (tag_vld_r[LAT-1] && div_result_tvalid) begin
        rsp_valid_r <= id2oh(tag_id_r[LAT-1]);
        rsp_data_r  <= div_result_tdata;
        rsp_flag_r  <= div_flag;
      end else if ((tag_vld_r[LAT-1] != div_result_tvalid) && guard_done_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Drain FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (flush) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!busy_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE:  state_nxt_s = ST_RUN;
      default:  state_nxt_s = ST_RUN;
    endcase
  end

  // Drain FSM state register and registered completion pulse.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r      <= ST_RUN;
      flush_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      flush_done_r <= (state_nxt_s == ST_DONE);
    end
  end

  assign div_a_tdata  = div_a_r;
  assign div_b_tdata  = div_b_r;
  assign div_a_tvalid = div_tvalid_r;
  assign div_b_tvalid = div_tvalid_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_data     = rsp_data_r;
  assign rsp_flag     = rsp_flag_r;
  assign flush_done   = flush_done_r;
  assign busy         = busy_s;
  assign err          = err_r;

endmodule

// File: doc/fdiv_share_arb.md
# fdiv_share_arb

Shares one pipelined floating-point divider (fixed issue-to-result latency, no result backpressure) among `NREQ` requesters. Per cycle it grants at most one requester, registers that requester's operands into the divider, and tags the operation with the requester ID. The tag rides a shift pipeline that matches the divider latency, and each result is routed back to its owner. It sits between the compute clients and the single divider instance. It also provides a drain/flush handshake and a sticky tag-mismatch error.

## Interface
Parameters:
- `EXP`, 5, exponent width of the operand format.
- `FRA`, 10, fraction width. Word width is `W = EXP+FRA+1`.
- `NREQ`, 4, number of requesters (2..8).
- `LAT`, 4, divider latency in cycles, from a `div_*_tvalid` sample to `div_result_tvalid`. Must equal the attached divider's latency (≥1).

Ports:
- `aclk` in 1: the single clock. All logic is on its rising edge.
- `aresetn` in 1: reset, synchronous, active-low.
- `req_valid` in NREQ: requester i has an operation pending.
- `req_a` in NREQ*W: dividend of requester i, at bits `[i*W +: W]`.
- `req_b` in NREQ*W: divisor of requester i, at bits `[i*W +: W]`.
- `req_ready` out NREQ: one-hot grant, combinational. A transfer occurs when `req_valid[i] & req_ready[i]`.
- `div_a_tdata`, `div_b_tdata` out W: registered operands to the divider.
- `div_a_tvalid`, `div_b_tvalid` out 1: registered, always equal to each other.
- `div_result_tdata` in W: divider result.
- `div_result_tvalid` in 1: divider result valid.
- `div_flag` in 3: divider zero/inf/NaN flags.
- `rsp_valid` out NREQ: one-hot, one-cycle response strobe.
- `rsp_data` out W: routed result.
- `rsp_flag` out 3: routed flags.
- `flush` in 1: request drain.
- `flush_done` out 1: one-cycle pulse when the drain completes.
- `busy` out 1: any tag in flight.
- `err` out 1: sticky tag mismatch.

## Operation
- State machine `RUN` / `DRAIN` / `DONE`. Reset state is `RUN`.
  - `RUN`: arbitration enabled. `flush=1` moves to `DRAIN`; no grant is issued in the cycle `flush` is sampled high.
  - `DRAIN`: `req_ready=0`. When the tag pipe is empty, move to `DONE`.
  - `DONE`: `flush_done=1` for one cycle, then return to `RUN`.
- Arbitration is round-robin. The search starts at pointer `p` and wraps modulo NREQ. After a grant to i, `p` becomes `(i+1) mod NREQ`. `p` is unchanged when there is no grant.
- On a grant to i, the next cycle drives `div_a_tdata=req_a[i]`, `div_b_tdata=req_b[i]` and `div_*_tvalid=1`. Otherwise tvalid is 0 and the data holds its last value.
- Tag pipe: `LAT` stages of {valid, id[clog2(NREQ)]}. Stage 0 loads when the divider tvalid is 1, and the pipe shifts every cycle.
- Match is checked at stage `LAT-1`, in the same cycle as `div_result_tvalid`:
  - Both valid: register `rsp_data`, `rsp_flag` and `rsp_valid[id]=1` for the next cycle.
  - Exactly one valid: no response, and `err` is set.
  - `err` clears only on reset.
- Post-reset guard: a counter suppresses `err` and drops stray divider results for `LAT` cycles after `aresetn` rises. Operations issued during the guard window are still tracked normally.
- `busy` is the OR of all tag-pipe valids and the divider tvalid register.

## Timing
- Throughput: one operation per cycle.
- Latency: accept at cycle t; divider tvalid at t+1; `div_result_tvalid` at t+1+LAT; `rsp_valid` at t+2+LAT.
- Reset values, for all outputs: `div_*_tvalid=0`, `div_*_tdata=0`, `rsp_valid=0`, `rsp_data=0`, `rsp_flag=0`, `flush_done=0`, `busy=0`, `err=0`.
- Reset also clears the tag pipe, sets `p=0`, and loads the guard counter with `LAT`.
- Reset mid-operation: in-flight operations are discarded and no responses are produced for them. The guard counter absorbs their late results.
- `req_ready` is forced to 0 during reset and in `DRAIN`/`DONE`.
- `flush` asserted with the tag pipe already empty: `RUN`→`DRAIN`→`DONE`, so `flush_done` pulses 2 cycles after `flush` is sampled.

## Configuration
- `FDIV_ARB_FIXPRIO_EN` defined: fixed priority, lowest index wins, and pointer `p` is not implemented.
- `FDIV_ARB_FIXPRIO_EN` undefined (default): round-robin as described above.
- Ports and latency are identical in both builds.

## Test plan
- Single request. NREQ=4, LAT=4; `req_valid=4'b0100`, a=0x4000 (2.0), b=0x3C00 (1.0); divider model returns 0x4000. Required: `req_ready=4'b0100` in the same cycle, `rsp_valid=4'b0100` with `rsp_data=0x4000` exactly 6 cycles later.
- Contention. `req_valid=4'b1111` held for 8 cycles. Required: grant sequence 0,1,2,3,0,1,2,3, and each `rsp_valid` arrives in the same order. With `FDIV_ARB_FIXPRIO_EN`: 8 grants to requester 0.
- Drain. Issue 3 operations, then pulse `flush` with `req_valid` still high. Required: no further grants, `flush_done` exactly once after the 3rd response, and grants resume the following cycle.
- Spurious result. Drive `div_result_tvalid=1` with the pipe empty, after the guard window has expired. Required: `err=1`, no `rsp_valid`, and `err` stays high until reset.
- Reset mid-flight. Issue 2 operations, then pull `aresetn=0` for 1 cycle; the divider model keeps emitting the 2 old results. Required: `err` stays 0, no `rsp_valid`, and a new request after reset returns correctly.
- Tag delivery. Issue back-to-back from requester 3 then requester 1, with the divider model emitting distinct values. Required: each `rsp_valid` bit carries its own requester's result, with `rsp_flag` passed through unchanged.
